// File: rtl/conv1x1_feeder_if.sv
// Signal bundle for conv1x1_feeder: kernel write port, pixel stream and pair outputs.
interface conv1x1_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int WADDR_W    = 5,
  parameter int OC_W       = 3
);
  logic                  w_we;
  logic [WADDR_W-1:0]    w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] Data_Out;
  logic [DATA_WIDTH-1:0] Kernel_Out;
  logic                  Valid_Out;
  logic                  Last_Out;
  logic [OC_W-1:0]       Oc_Out;
  logic                  busy;

  modport slave (
    input  w_we, w_addr, w_data, s_data, s_valid,
    output w_drop, s_ready, Data_Out, Kernel_Out, Valid_Out, Last_Out, Oc_Out, busy
  );

  modport master (
    output w_we, w_addr, w_data, s_data, s_valid,
    input  w_drop, s_ready, Data_Out, Kernel_Out, Valid_Out, Last_Out, Oc_Out, busy
  );
endinterface

// File: rtl/conv1x1_feeder.sv
// 1x1 convolution feeder: collects one pixel, then emits C_OUT*C_IN (data, kernel) pairs.
// Optional macro CONV1X1_FEEDER_PINGPONG_EN adds a second pixel buffer so filling overlaps streaming.
module conv1x1_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int C_IN       = 4,
  parameter int C_OUT      = 8,
  parameter int WADDR_W    = (C_IN * C_OUT > 1) ? $clog2(C_IN * C_OUT) : 1
) (
  input logic             clk,
  input logic             rst,
  conv1x1_feeder_if.slave bus
);
  localparam int NK      = C_IN * C_OUT;
  localparam int KADDR_W = (NK > 1) ? $clog2(NK) : 1;
  localparam int CIN_W   = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int OC_W    = (C_OUT > 1) ? $clog2(C_OUT) : 1;
  localparam logic [31:0]      NK_U    = 32'(NK);
  localparam logic [CIN_W-1:0] IC_LAST = CIN_W'(C_IN - 1);
  localparam logic [OC_W-1:0]  OC_LAST = OC_W'(C_OUT - 1);
`ifdef CONV1X1_FEEDER_PINGPONG_EN
  localparam int   NBUF = 2;
  localparam logic PP   = 1'b1;
`else
  localparam int   NBUF = 1;
  localparam logic PP   = 1'b0;
`endif

  typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_STREAM = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CIN_W-1:0]      ic_in_q, ic_in_d, ic_q, ic_d;
  logic [OC_W-1:0]       oc_q, oc_d;
  logic [NBUF-1:0]       full_q, full_d;
  logic                  fill_sel_q, fill_sel_d, rd_sel_q, rd_sel_d;
  logic                  s_ready_q, s_ready_d, busy_q, busy_d, w_drop_q, w_drop_d;
  logic                  valid_q, valid_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, kern_q, kern_d;
  logic [OC_W-1:0]       oc_out_q, oc_out_d;

  logic [DATA_WIDTH-1:0] pix_q   [NBUF][C_IN];
  logic [DATA_WIDTH-1:0] kbank_q [NK];

  logic               hs_s, last_in_s, last_ic_s, last_pair_s, other_sel_s, w_oor_s, k_we_s;
  logic [KADDR_W-1:0] k_rd_idx_s, k_wr_idx_s;

  // Handshake, pair-position and kernel-write decode
  always_comb begin
    hs_s        = bus.s_valid && s_ready_q;
    last_in_s   = hs_s && (ic_in_q == IC_LAST);
    last_ic_s   = (ic_q == IC_LAST);
    last_pair_s = (state_q == ST_STREAM) && last_ic_s && (oc_q == OC_LAST);
    other_sel_s = rd_sel_q ^ PP;
    w_oor_s     = (32'(bus.w_addr) >= NK_U);
    k_we_s      = bus.w_we && !w_oor_s && (state_q == ST_LOAD);
    k_wr_idx_s  = KADDR_W'(bus.w_addr);
    k_rd_idx_s  = KADDR_W'(32'(oc_q) * 32'(C_IN) + 32'(ic_q));
  end

  // Next-state, counters, buffer ownership and registered-output values
  always_comb begin
    state_d    = state_q;
    ic_in_d    = ic_in_q;
    ic_d       = ic_q;
    oc_d       = oc_q;
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    rd_sel_d   = rd_sel_q;

    if (hs_s) begin
      if (last_in_s) begin
        ic_in_d            = '0;
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d         = fill_sel_q ^ PP;
      end else begin
        ic_in_d = ic_in_q + CIN_W'(1);
      end
    end else begin
      ic_in_d = ic_in_q;
    end

    case (state_q)
      ST_LOAD: begin
        if (last_in_s) begin
          state_d  = ST_STREAM;
          rd_sel_d = fill_sel_q;
          ic_d     = '0;
          oc_d     = '0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_STREAM: begin
        if (last_ic_s) begin
          ic_d = '0;
          oc_d = oc_q + OC_W'(1);
        end else begin
          ic_d = ic_q + CIN_W'(1);
        end
        if (last_pair_s) begin
          full_d[rd_sel_q] = 1'b0;
          oc_d             = '0;
          // A completed second buffer chains straight into the next stream
          if (PP && (full_q[other_sel_s] || last_in_s)) begin
            state_d  = ST_STREAM;
            rd_sel_d = other_sel_s;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    valid_d = (state_q == ST_STREAM);
    if (valid_d) begin
      data_d   = pix_q[rd_sel_q][ic_q];
      kern_d   = kbank_q[k_rd_idx_s];
      last_d   = last_ic_s;
      oc_out_d = oc_q;
    end else begin
      data_d   = '0;
      kern_d   = '0;
      last_d   = 1'b0;
      oc_out_d = '0;
    end
    busy_d    = (state_d == ST_STREAM);
    s_ready_d = !full_d[fill_sel_d];
    w_drop_d  = bus.w_we && (w_oor_s || (state_q == ST_STREAM));
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      ic_in_q    <= '0;
      ic_q       <= '0;
      oc_q       <= '0;
      full_q     <= '0;
      fill_sel_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      s_ready_q  <= 1'b1;
      busy_q     <= 1'b0;
      w_drop_q   <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      kern_q     <= '0;
      oc_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      ic_in_q    <= ic_in_d;
      ic_q       <= ic_d;
      oc_q       <= oc_d;
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      rd_sel_q   <= rd_sel_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      w_drop_q   <= w_drop_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      kern_q     <= kern_d;
      oc_out_q   <= oc_out_d;
    end
  end

  // Pixel and kernel storage; the kernel bank deliberately survives reset
  always_ff @(posedge clk) begin
    if (hs_s) begin
      pix_q[fill_sel_q][ic_in_q] <= bus.s_data;
    end
    if (k_we_s) begin
      kbank_q[k_wr_idx_s] <= bus.w_data;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.busy       = busy_q;
  assign bus.w_drop     = w_drop_q;
  assign bus.Valid_Out  = valid_q;
  assign bus.Last_Out   = last_q;
  assign bus.Data_Out   = data_q;
  assign bus.Kernel_Out = kern_q;
  assign bus.Oc_Out     = oc_out_q;
endmodule

// File: tb/tb_conv1x1_feeder.sv
// Directed bench for conv1x1_feeder (C_IN=4, C_OUT=8, address port widened to reach index 32).
module tb_conv1x1_feeder;
  localparam int DW = 32;
  localparam int CI = 4;
  localparam int CO = 8;
  localparam int NK = CI * CO;
  localparam int AW = 6;
  localparam int OW = 3;

  typedef logic [DW-1:0] pix_t [CI];
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_drop;
  } wvec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [DW-1:0] kexp [NK];

  conv1x1_feeder_if #(.DATA_WIDTH(DW), .WADDR_W(AW), .OC_W(OW)) bus ();

  conv1x1_feeder #(.DATA_WIDTH(DW), .C_IN(CI), .C_OUT(CO), .WADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_k(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_drop);
    bus.w_we   = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    step();
    bus.w_we = 1'b0;
    chk("w_drop", {63'd0, bus.w_drop}, {63'd0, exp_drop});
    if (!exp_drop) kexp[a[4:0]] = d;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int cnt = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && cnt < 100) begin
      step();
      cnt++;
    end
    if (cnt == 100) chk("s_ready_wait", {63'd0, bus.s_ready}, 64'd1);
    step();
    bus.s_valid = 1'b0;
  endtask

  // Entered at the negedge right after the edge that accepted the last channel word
  task automatic check_stream(input pix_t p, input bit hold, input logic [DW-1:0] hw, input bit inj);
    chk("lat_valid0", {63'd0, bus.Valid_Out}, 64'd0);
    chk("stream_ready0", {63'd0, bus.s_ready}, 64'd0);
    if (hold) begin
      bus.s_valid = 1'b1;
      bus.s_data  = hw;
    end
    for (int n = 0; n < NK; n++) begin
      step();
      chk("valid", {63'd0, bus.Valid_Out}, 64'd1);
      chk("data", 64'(bus.Data_Out), 64'(p[n % CI]));
      chk("kernel", 64'(bus.Kernel_Out), 64'(kexp[n]));
      chk("oc", 64'(bus.Oc_Out), 64'(n / CI));
      chk("last", {63'd0, bus.Last_Out}, {63'd0, (n % CI) == CI - 1});
      chk("s_ready", {63'd0, bus.s_ready}, {63'd0, n == NK - 1});
      chk("busy", {63'd0, bus.busy}, {63'd0, n != NK - 1});
      if (inj && n == 1) begin
        bus.w_we   = 1'b1;
        bus.w_addr = 6'd5;
        bus.w_data = 32'h0000_DEAD;
      end
      if (inj && n == 2) begin
        chk("drop_stream", {63'd0, bus.w_drop}, 64'd1);
        bus.w_we = 1'b0;
      end
      if (inj && n == 3) chk("drop_pulse", {63'd0, bus.w_drop}, 64'd0);
    end
    step();
    chk("valid_end", {63'd0, bus.Valid_Out}, 64'd0);
    if (hold) bus.s_valid = 1'b0;
  endtask

  initial begin
    pix_t  pa, pb, pc, pd, pe, pf;
    wvec_t wtab [6];

    wtab[0] = '{6'd32, 32'h0000_0BAD, 1'b1};
    wtab[1] = '{6'd47, 32'h0000_0BAE, 1'b1};
    wtab[2] = '{6'd63, 32'h0000_BEEF, 1'b1};
    wtab[3] = '{6'd7,  32'h0000_0107, 1'b0};
    wtab[4] = '{6'd31, 32'h0000_011F, 1'b0};
    wtab[5] = '{6'd0,  32'h0000_0100, 1'b0};
    for (int i = 0; i < CI; i++) begin
      pa[i] = 32'hA0 + 32'(i);
      pb[i] = 32'hB0 + 32'(i);
      pc[i] = 32'hC0 + 32'(i);
      pd[i] = 32'hD0 + 32'(i);
      pe[i] = 32'hE0 + 32'(i);
      pf[i] = 32'hF0 + 32'(i);
    end

    rst         = 1'b0;
    bus.w_we    = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) step();
    chk("rst_valid", {63'd0, bus.Valid_Out}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_drop", {63'd0, bus.w_drop}, 64'd0);
    chk("rst_data", 64'(bus.Data_Out), 64'd0);
    chk("rst_oc", 64'(bus.Oc_Out), 64'd0);
    rst = 1'b1;
    step();
    chk("rel_ready", {63'd0, bus.s_ready}, 64'd1);
    chk("rel_busy", {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < NK; i++) write_k(AW'(i), 32'h100 + 32'(i), 1'b0);
    for (int r = 0; r < 6; r++) write_k(wtab[r].addr, wtab[r].data, wtab[r].exp_drop);

    // Pixel A with a held next word (backpressure) and a rejected write mid-stream
    for (int i = 0; i < CI; i++) send_word(pa[i]);
    check_stream(pa, 1'b1, pb[0], 1'b1);
    for (int i = 1; i < CI; i++) send_word(pb[i]);
    check_stream(pb, 1'b0, '0, 1'b0);

    // Kernel write coinciding with the last-channel handshake
    for (int i = 0; i < CI - 1; i++) send_word(pc[i]);
    bus.w_we   = 1'b1;
    bus.w_addr = 6'd9;
    bus.w_data = 32'h0000_0999;
    send_word(pc[CI-1]);
    bus.w_we = 1'b0;
    chk("same_cycle_drop", {63'd0, bus.w_drop}, 64'd0);
    kexp[9] = 32'h0000_0999;
    check_stream(pc, 1'b0, '0, 1'b0);

    // Stall between channel words
    send_word(pd[0]);
    send_word(pd[1]);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", {63'd0, bus.Valid_Out}, 64'd0);
      chk("stall_ready", {63'd0, bus.s_ready}, 64'd1);
    end
    send_word(pd[2]);
    send_word(pd[3]);
    check_stream(pd, 1'b0, '0, 1'b0);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < CI; i++) send_word(pe[i]);
    repeat (5) step();
    chk("pre_rst_valid", {63'd0, bus.Valid_Out}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, bus.Valid_Out}, 64'd0);
    chk("arst_data", 64'(bus.Data_Out), 64'd0);
    chk("arst_kernel", 64'(bus.Kernel_Out), 64'd0);
    chk("arst_oc", 64'(bus.Oc_Out), 64'd0);
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("arel_ready", {63'd0, bus.s_ready}, 64'd1);
    chk("arel_busy", {63'd0, bus.busy}, 64'd0);
    chk("arel_valid", {63'd0, bus.Valid_Out}, 64'd0);
    for (int i = 0; i < CI; i++) send_word(pf[i]);
    check_stream(pf, 1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
